instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset (bits [1:0] SHALL be treated as 00).
REQ-002 The ports SHALL be, one per line:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous and active-low
- imem_req  output  1  instruction-memory read request
- imem_addr  output  32  word-aligned fetch address
- imem_ready  input  1  memory response valid this cycle
- imem_rdata  input  32  instruction word, valid when imem_ready=1
- redirect_valid  input  1  jump/taken-branch redirect from execute
- redirect_pc  input  32  redirect target address
- if_valid  output  1  held instruction valid toward decode/control
- id_ready  input  1  decode accepts instruction this cycle
- if_instr  output  32  held instruction word
- if_pc  output  32  address of the held instruction
- Opcode  output  6  if_instr[31:26], feeds control-unit opcode input
- func  output  6  if_instr[5:0], feeds control-unit func input

Function
REQ-003 The FSM SHALL have states IDLE, FETCH and HOLD.
REQ-004 IDLE SHALL last exactly one cycle after reset release, then go to FETCH.
REQ-005 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc; in IDLE and HOLD, imem_req SHALL be 0.
REQ-006 In FETCH with imem_ready=1 and no redirect:
- if_instr<=imem_rdata
- if_pc<=pc
- pc<=pc+4
- go to HOLD
REQ-007 In FETCH with imem_ready=0, the FSM SHALL stay in FETCH with imem_addr stable.
REQ-008 if_valid SHALL be 1 exactly in HOLD; if_instr, if_pc, Opcode and func SHALL be stable while in HOLD.
REQ-009 In HOLD with id_ready=1 and no redirect, the FSM SHALL go to FETCH next cycle (handshake = if_valid&id_ready).
REQ-010 In HOLD with id_ready=0, the FSM SHALL remain in HOLD indefinitely.
REQ-011 Minimum throughput SHALL be one instruction per 2 cycles: response-to-if_valid latency 1 cycle, accept-to-next-request latency 1 cycle.
REQ-012 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-013 redirect_valid=1 in any state SHALL take priority over imem_ready and id_ready:
- pc<=redirect_pc with bits [1:0] forced to 00
- next state FETCH
- any same-cycle imem_rdata discarded
- any held instruction dropped (if_valid=0 next cycle)
REQ-014 Redirect in IDLE SHALL override RESET_PC.
REQ-015 Redirect and id_ready both high in HOLD SHALL count as acceptance of the held instruction and also apply the redirect.
REQ-016 Opcode and func SHALL be purely combinational slices of if_instr, with no added latency.

Reset
REQ-017 While rst_n=0:
- state=IDLE, pc=RESET_PC
- if_instr=0, if_pc=0
- imem_req=0, if_valid=0, Opcode=0, func=0
REQ-018 Reset assertion mid-transaction SHALL abandon the request immediately; a late imem_ready SHALL be ignored.

Configuration
REQ-019 With macro FETCH_STALL_CNT_EN defined:
- the block SHALL add output stall_cnt [15:0], reset to 0
- stall_cnt SHALL increment each cycle in FETCH with imem_ready=0 and redirect_valid=0
- stall_cnt SHALL saturate at 16'hFFFF
REQ-020 Without FETCH_STALL_CNT_EN, the stall_cnt port and counter SHALL be absent, with otherwise identical behaviour.

Verification
REQ-021 Reset, RESET_PC=0, memory always ready, id_ready=1 -> imem_addr 0,4,8 on cycles 1,3,5; if_valid pulses on cycles 2,4,6.
REQ-022 imem_rdata=32'h0000_0820 (add) in HOLD -> Opcode=6'b000000, func=6'b100000; id_ready=0 for 5 cycles -> if_valid stays 1 and all outputs stay stable.
REQ-023 HOLD with redirect_valid=1, redirect_pc=32'h0000_0103 -> next cycle if_valid=0, imem_req=1, imem_addr=32'h0000_0100.
REQ-024 FETCH at 32'hFFFF_FFFC with imem_ready=1 -> next fetch address 32'h0000_0000.
REQ-025 imem_ready=0 for 3 cycles, then rst_n pulsed low -> imem_req=0 immediately; with FETCH_STALL_CNT_EN, stall_cnt reads 3 before reset and 0 after.
REQ-026 FETCH with imem_ready=1 and redirect_valid=1 in the same cycle -> rdata discarded, if_valid stays 0, next imem_addr = redirect target.

Source files
------------

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_if
// Description : Fetch-stage bundle. Carries the instruction-memory request and
//               response, the execute redirect and the decode handshake.
// Revision    : 1.0  initial release
// ============================================================================
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        id_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [5:0]  Opcode;
    logic [5:0]  func;

    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc, Opcode, func,
        input  imem_ready, imem_rdata, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc, Opcode, func,
        output imem_ready, imem_rdata, redirect_valid, redirect_pc, id_ready
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch stage, IDLE/FETCH/HOLD FSM with redirect.
//               Optional macro FETCH_STALL_CNT_EN adds a saturating stall_cnt.
// Revision    : 1.0  initial release
// ============================================================================
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef FETCH_STALL_CNT_EN
    output logic [15:0]          stall_cnt,
`endif
    instr_fetch_if.master        bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      state_q,    state_d;
    logic [31:0] pc_q,       pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q,    if_pc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC_ALIGNED;
            if_instr_q <= 32'h0000_0000;
            if_pc_q    <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        // Redirect wins everywhere: any response or held word is dropped.
        if (bus.redirect_valid) begin
            pc_d    = {bus.redirect_pc[31:2], 2'b00};
            state_d = FETCH;
        end else begin
            unique case (state_q)
                IDLE: state_d = FETCH;
                FETCH: begin
                    if (bus.imem_ready) begin
                        if_instr_d = bus.imem_rdata;
                        if_pc_d    = pc_q;
                        pc_d       = pc_q + 32'd4;
                        state_d    = HOLD;
                    end
                end
                HOLD: begin
                    if (bus.id_ready) begin
                        state_d = FETCH;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.imem_req  = (state_q == FETCH);
    assign bus.imem_addr = pc_q;
    assign bus.if_valid  = (state_q == HOLD);
    assign bus.if_instr  = if_instr_q;
    assign bus.if_pc     = if_pc_q;
    assign bus.Opcode    = if_instr_q[31:26];
    assign bus.func      = if_instr_q[5:0];

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == FETCH) && !bus.imem_ready && !bus.redirect_valid &&
            (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire
